// File: rtl/icache.sv
// Direct-mapped instruction cache with a combinational hit path and a
// blocking, in-order burst refill of one line per miss.
module icache #(
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned LINE_W = TAG_W + IDX_W;

    typedef enum logic {StIdle, StRefill} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] w_valid_next;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES*WORDS_PER_LINE];
    logic [LINE_W-1:0]    r_line;
    logic [OFF_W-1:0]     r_beat;
    logic                 r_abort;

    logic [TAG_W-1:0] w_pc_tag;
    logic [IDX_W-1:0] w_pc_idx;
    logic [OFF_W-1:0] w_pc_off;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_hit;
    logic             w_last;
    logic             w_beat_fire;
    logic             w_unused_pc;

    assign w_pc_tag    = pc[31 -: TAG_W];
    assign w_pc_idx    = pc[2+OFF_W +: IDX_W];
    assign w_pc_off    = pc[2 +: OFF_W];
    assign w_fill_idx  = r_line[IDX_W-1:0];
    assign w_last      = (r_beat == OFF_W'(WORDS_PER_LINE - 1));
    assign w_beat_fire = (r_state == StRefill) && mem_ready;
    assign w_hit       = (r_state == StIdle) && r_valid[w_pc_idx]
                         && (r_tag[w_pc_idx] == w_pc_tag);
    assign w_unused_pc = ^pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (!w_hit) w_state_next = StRefill;
            StRefill: if (mem_ready && w_last) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // An abort (flush seen during the burst) keeps the refilled line invalid.
    always_comb begin
        w_valid_next = r_valid;
        if (flush) begin
            w_valid_next = '0;
        end
        if (w_beat_fire && w_last && !r_abort && !flush) begin
            w_valid_next[w_fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_line  <= '0;
            r_beat  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            if (r_state == StIdle && !w_hit) begin
                r_line  <= pc[31:2+OFF_W];
                r_beat  <= '0;
                r_abort <= 1'b0;
            end else if (r_state == StRefill) begin
                if (flush) begin
                    r_abort <= 1'b1;
                end
                if (mem_ready) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_fire) begin
            r_data[{w_fill_idx, r_beat}] <= mem_rdata;
            if (w_last) begin
                r_tag[w_fill_idx] <= r_line[LINE_W-1:IDX_W];
            end
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_addr     = '0;
        icache_stall = 1'b0;
        inst         = '0;
        if (!rst) begin
            icache_stall = !w_hit;
            inst         = r_data[{w_pc_idx, w_pc_off}];
            if (r_state == StRefill) begin
                mem_req  = 1'b1;
                mem_addr = {r_line, r_beat, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetches, checked against a
// line-level cache model and a fixed instruction-memory image.
module tb_icache;

    localparam int NL  = 64;
    localparam int WPL = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bit          ref_valid [NL];
    logic [31:0] ref_tag   [NL];

    icache #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .flush        (flush),
        .inst         (inst),
        .icache_stall (icache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: words 0..3 are 0xA0..0xA3, elsewhere a hash.
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a < 32'h10) return 32'hA0 + (a >> 2);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    assign mem_rdata = memval(mem_addr);

    function automatic int line_idx(input logic [31:0] a);
        return int'((a >> (2 + $clog2(WPL))) % NL);
    endfunction

    function automatic logic [31:0] line_tag(input logic [31:0] a);
        return a >> (2 + $clog2(WPL) + $clog2(NL));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return ref_valid[line_idx(a)] && (ref_tag[line_idx(a)] == line_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge. On a miss, runs the whole burst, inserting
    // not-ready cycles before each beat; optional flush or reset at a chosen beat.
    task automatic do_fetch(input logic [31:0] a, input int maxw, input int bp_beat,
                            input int bp_n, input int flush_beat, input int rst_beat,
                            input bit scramble);
        logic [31:0] base;
        bit          hit;
        bit          aborted;
        int          nwait;
        pc        = a;
        flush     = 1'b0;
        mem_ready = 1'b0;
        #1;
        hit = model_hit(a);
        chk("lookup_stall", icache_stall, {31'b0, !hit});
        chk("lookup_req", mem_req, 32'h0);
        if (hit) begin
            chk("hit_inst", inst, memval(a & ~32'h3));
            @(negedge clk);
            return;
        end
        base    = a & ~32'(WPL * 4 - 1);
        aborted = 1'b0;
        @(negedge clk);
        for (int beat = 0; beat < WPL; beat++) begin
            nwait = (beat == bp_beat) ? bp_n : int'($urandom_range(0, maxw));
            for (int w = 0; w <= nwait; w++) begin
                mem_ready = (w == nwait);
                flush     = (beat == flush_beat) && (w == 0);
                if (scramble) pc = $urandom;
                #1;
                chk("refill_req", mem_req, 32'h1);
                chk("refill_addr", mem_addr, base + 32'(4 * beat));
                chk("refill_stall", icache_stall, 32'h1);
                if (flush) begin
                    aborted = 1'b1;
                    model_clear();
                end
                if (beat == rst_beat && w == 0) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_req", mem_req, 32'h0);
                    chk("rst_addr", mem_addr, 32'h0);
                    chk("rst_stall", icache_stall, 32'h0);
                    chk("rst_inst", inst, 32'h0);
                    model_clear();
                    @(negedge clk);
                    rst       = 1'b0;
                    mem_ready = 1'b0;
                    flush     = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
        pc        = a;
        ref_tag[line_idx(a)] = line_tag(a);
        if (!aborted) ref_valid[line_idx(a)] = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a);
        do_fetch(a, 0, -1, 0, -1, -1, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        model_clear();
        rst       = 1'b1;
        pc        = 32'h0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_stall", icache_stall, 32'h0);
        chk("reset_req", mem_req, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, then hits in the same line.
        fetch(32'h0);
        fetch(32'h0);
        fetch(32'h8);

        // Conflict on index 0.
        fetch(32'h400);
        fetch(32'h40C);
        fetch(32'h0);
        fetch(32'h4);

        // Backpressure: three not-ready cycles before beat 2.
        do_fetch(32'h104, 0, 2, 3, -1, -1, 1'b0);
        fetch(32'h108);

        // Flush during refill at beat 1: line stays invalid, refetch refills.
        do_fetch(32'h20, 0, -1, 0, 1, -1, 1'b0);
        fetch(32'h20);
        fetch(32'h24);

        // Flush in IDLE alongside a hit.
        pc    = 32'h28;
        flush = 1'b1;
        #1;
        chk("flush_idle_stall", icache_stall, 32'h0);
        chk("flush_idle_inst", inst, memval(32'h28));
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        fetch(32'h28);
        fetch(32'h28);

        // pc wanders during the burst.
        do_fetch(32'h7F0, 1, -1, 0, -1, -1, 1'b1);
        fetch(32'h7F4);

        // Random fetches over a small tag range to mix hits, misses, conflicts.
        for (int i = 0; i < 60; i++) begin
            a = {20'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 4'($urandom)};
            a = (a >> 4) << 2 | (a & 32'h3);
            do_fetch(a, 2, -1, 0, (i % 17 == 5) ? 2 : -1, -1, i[0]);
        end

        // Reset mid-refill, then the same address misses again.
        fetch(32'h0);
        fetch(32'h0);
        do_fetch(32'h200, 0, -1, 0, -1, 2, 1'b0);
        fetch(32'h0);
        fetch(32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter NUM_LINES, 64: direct-mapped line count, power of two.
REQ-002 Parameter WORDS_PER_LINE, 4: 32-bit words per line, power of two >= 2.
REQ-003 Port clk  input  1  single clock, all state updates on posedge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port pc  input  32  fetch address from the PC register; pc[1:0] ignored.
REQ-006 Port flush  input  1  invalidate all lines (fence.i).
REQ-007 Port inst  output  32  instruction at pc; meaningful only when icache_stall=0.
REQ-008 Port icache_stall  output  1  1 = inst not available, PC and fetch stage hold.
REQ-009 Port mem_req  output  1  refill read request to instruction memory.
REQ-010 Port mem_addr  output  32  word-aligned refill beat address.
REQ-011 Port mem_ready  input  1  memory beat accept; mem_rdata valid in the same cycle.
REQ-012 Port mem_rdata  input  32  refill beat data.

Function
REQ-013 Address split SHALL be: byte [1:0], word offset next log2(WORDS_PER_LINE) bits, index next log2(NUM_LINES) bits, tag the remaining upper bits.
REQ-014 Storage SHALL be per line: valid bit, tag, WORDS_PER_LINE data words.
REQ-015 Hit SHALL be: FSM in IDLE, line valid, stored tag equal to pc tag.
REQ-016 Hit path SHALL be combinational: inst = addressed word, icache_stall=0 in the same cycle pc is presented.
REQ-017 icache_stall SHALL be 1 in every cycle that is not a hit, including the cycle a miss is first seen and every REFILL cycle.
REQ-018 FSM states SHALL be IDLE and REFILL.
REQ-019 IDLE->REFILL on a miss at posedge: latch line base (pc with offset and byte bits zeroed), clear beat counter, clear abort flag.
REQ-020 In REFILL: mem_req=1, mem_addr = line base + 4*beat. Both SHALL hold stable until mem_ready=1.
REQ-021 On each posedge with mem_req=1 and mem_ready=1: write mem_rdata into word[beat] of the latched index, then beat increments.
REQ-022 On the last beat, beat counter wraps to 0, FSM returns to IDLE, and tag is written. Valid=1 unless the abort flag is set.
REQ-023 Miss penalty with mem_ready tied high SHALL be WORDS_PER_LINE+1 cycles of icache_stall=1; the next cycle is a hit.
REQ-024 mem_req SHALL be 0 in IDLE; no request is issued on a hit.
REQ-025 flush in IDLE: all valid bits cleared at the next posedge. A hit in that same cycle still completes combinationally.
REQ-026 flush in REFILL: all valid bits cleared and the abort flag set. The burst runs to completion (no mid-burst abandon) and the refilled line stays invalid.
REQ-027 pc changes during REFILL SHALL NOT alter the burst. On return to IDLE, lookup uses the current pc.
REQ-028 A miss to the index being refilled is only evaluated after return to IDLE; conflict eviction is replace-on-refill.

Reset
REQ-029 While rst=1, without waiting for a clock edge: FSM=IDLE, all valid bits=0, beat=0, abort=0, mem_req=0, mem_addr=0, icache_stall=0, inst=0.
REQ-030 Data and tag arrays need not be reset.
REQ-031 rst asserted mid-REFILL SHALL drop mem_req immediately. The partially filled line stays invalid.

Verification
REQ-032 Cold miss: reset, pc=0x0, mem_ready=1, words 0xA0..0xA3 -> mem_addr 0x0,0x4,0x8,0xC on 4 consecutive cycles, then icache_stall=0, inst=0xA0.
REQ-033 Hit: after REQ-032, pc=0x8 -> same cycle icache_stall=0, inst=0xA2, mem_req=0.
REQ-034 Conflict: pc=0x400 (index 0, tag 1) -> refill 0x400..0x40C. Return to pc=0x0 -> miss and refill again.
REQ-035 Backpressure: mem_ready low 3 cycles before beat 2 -> mem_addr held at base+0x8, mem_req held at 1. Penalty is 3 cycles longer.
REQ-036 Flush in REFILL at beat 1 for pc=0x20 -> all 4 beats complete, then a second 4-beat refill of 0x20.
REQ-037 rst pulse mid-REFILL -> mem_req=0 before the next posedge. After release, pc=0x0 misses again.
